seq_shift_add_mult: RTL

//  Iterative shift-add multiplier, the parametrised successor of our combinational 6-bit multiplier.

---
 rtl/mult_pkg.sv | 29 ++
 rtl/mult_pp_step.sv | 26 ++
 rtl/seq_shift_add_mult.sv | 131 +++++++++++++
 3 files changed

// File: rtl/mult_pkg.sv
// Shared types and helpers for the iterative shift-add multiplier.
// Holds the FSM state encoding and the operand magnitude function.
package mult_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    // Widest operand abs_mag can handle; callers zero-extend into this width.
    localparam int MAX_W = 64;

    // Magnitude of a width-bit value; the most negative value maps to 2^(width-1).
    function automatic logic [MAX_W-1:0] abs_mag(input logic [MAX_W-1:0] value,
                                                 input int              width,
                                                 input logic            is_signed);
        logic [MAX_W-1:0] one;
        logic [MAX_W-1:0] mask;
        one  = {{(MAX_W-1){1'b0}}, 1'b1};
        mask = (width >= MAX_W) ? {MAX_W{1'b1}} : ((one << width) - one);
        if (is_signed && value[width-1]) begin
            abs_mag = (~value + one) & mask;
        end else begin
            abs_mag = value & mask;
        end
    endfunction

endpackage

// File: rtl/mult_pp_step.sv
// Combinational partial product for one iteration:
// (a_mag * b_slice) << shift, computed at full product width.
module mult_pp_step #(
    parameter int WIDTH = 6,
    parameter int K     = 1,
    parameter int SHW   = 5
) (
    input  logic [WIDTH-1:0]   a_mag,
    input  logic [K-1:0]       b_slice,
    input  logic [SHW-1:0]     shift,
    output logic [2*WIDTH-1:0] pp
);

    logic [2*WIDTH-1:0] a_ext;
    logic [2*WIDTH-1:0] b_ext;
    logic [2*WIDTH-1:0] prod;

    // a_mag * b_slice < 2^(WIDTH+K) and shift <= WIDTH-K, so nothing is lost at 2*WIDTH bits.
    always_comb begin
        a_ext = {{WIDTH{1'b0}}, a_mag};
        b_ext = {{(2*WIDTH-K){1'b0}}, b_slice};
        prod  = a_ext * b_ext;
        pp    = prod << shift;
    end

endmodule

// File: rtl/seq_shift_add_mult.sv
// Iterative shift-add multiplier retiring K multiplier bits per cycle, with
// per-operation signed/unsigned mode and valid/ready handshakes on both sides.
module seq_shift_add_mult
    import mult_pkg::*;
#(
    parameter int WIDTH     = 6,
    parameter int K         = 1,
    parameter int SIGNED_EN = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_a,
    input  logic [WIDTH-1:0]   in_b,
    input  logic               in_signed,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] out_p
);

    localparam int N   = WIDTH / K;
    localparam int CW  = $clog2(N + 1);
    localparam int SHW = $clog2(2 * WIDTH) + 1;
    localparam logic [SHW-1:0] K_SH   = SHW'(K);
    localparam logic [CW-1:0]  N_CNT  = CW'(N);
    localparam logic           SEN    = (SIGNED_EN != 0);

    generate
        if (K < 1 || K > WIDTH || (WIDTH % K) != 0) begin : g_bad_k
            $error("seq_shift_add_mult: K must be in 1..WIDTH and divide WIDTH");
        end
        if (WIDTH > MAX_W) begin : g_bad_width
            $error("seq_shift_add_mult: WIDTH exceeds mult_pkg::MAX_W");
        end
    endgenerate

    state_t             state, state_next;
    logic [WIDTH-1:0]   a_mag, a_mag_next;
    logic [WIDTH-1:0]   b_mag, b_mag_next;
    logic               neg, neg_next;
    logic [2*WIDTH-1:0] acc, acc_next;
    logic [CW-1:0]      cnt, cnt_next;
    logic [2*WIDTH-1:0] p_next;
    logic               valid_next;
    logic               signed_op;
    logic [SHW-1:0]     shift;
    logic [2*WIDTH-1:0] pp;

    assign signed_op = in_signed & SEN;
    assign in_ready  = (state == IDLE) && !rst;
    assign shift     = SHW'(cnt) * K_SH;

    mult_pp_step #(
        .WIDTH (WIDTH),
        .K     (K),
        .SHW   (SHW)
    ) u_pp_step (
        .a_mag   (a_mag),
        .b_slice (b_mag[K-1:0]),
        .shift   (shift),
        .pp      (pp)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            a_mag     <= '0;
            b_mag     <= '0;
            neg       <= 1'b0;
            acc       <= '0;
            cnt       <= '0;
            out_p     <= '0;
            out_valid <= 1'b0;
        end else begin
            state     <= state_next;
            a_mag     <= a_mag_next;
            b_mag     <= b_mag_next;
            neg       <= neg_next;
            acc       <= acc_next;
            cnt       <= cnt_next;
            out_p     <= p_next;
            out_valid <= valid_next;
        end
    end

    // BUSY spends N cycles accumulating and one more to apply the sign into out_p.
    always_comb begin
        state_next = state;
        a_mag_next = a_mag;
        b_mag_next = b_mag;
        neg_next   = neg;
        acc_next   = acc;
        cnt_next   = cnt;
        p_next     = out_p;
        valid_next = out_valid;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    a_mag_next = WIDTH'(abs_mag(MAX_W'(in_a), WIDTH, signed_op));
                    b_mag_next = WIDTH'(abs_mag(MAX_W'(in_b), WIDTH, signed_op));
                    neg_next   = signed_op & (in_a[WIDTH-1] ^ in_b[WIDTH-1]);
                    acc_next   = '0;
                    cnt_next   = '0;
                    state_next = BUSY;
                end
            end
            BUSY: begin
                if (cnt == N_CNT) begin
                    p_next     = neg ? (~acc + 1'b1) : acc;
                    valid_next = 1'b1;
                    state_next = DONE;
                end else begin
                    acc_next   = acc + pp;
                    b_mag_next = b_mag >> K;
                    cnt_next   = cnt + 1'b1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    valid_next = 1'b0;
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule
